// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: hex glyph table, blank pattern,
// segment bit positions and a polarity helper. Patterns are stored active-low.
package seg7_pkg;

  // Bit positions inside a {g,f,e,d,c,b,a} pattern
  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [0:15][6:0] HEX_TABLE = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  function automatic logic [6:0] seg_polarity(input logic [6:0] pat_al, input logic active_low);
    return active_low ? pat_al : ~pat_al;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus between the value source and the scan driver: load strobe/value in,
// registered segment/digit drive and the frame pulse out.
interface seg7_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  import seg7_pkg::*;

  logic                    load;
  logic [4*NUM_DIGITS-1:0] value_in;
  logic [6:0]              seg_out;
  logic [NUM_DIGITS-1:0]   dig_sel;
  logic                    frame_done;

  modport master (
    output load, value_in,
    input  seg_out, dig_sel, frame_done
  );

  modport slave (
    input  load, value_in,
    output seg_out, dig_sel, frame_done
  );
endinterface

// File: rtl/seg7_hex_lut.sv
// Combinational nibble to active-low 7-segment glyph lookup.
module seg7_hex_lut
  import seg7_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);
  always_comb begin
    o_seg = HEX_TABLE[i_nibble];
  end
endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed hex display scanner with per-slot anti-ghost blanking.
// Optional leading-zero suppression is enabled by defining SEG7_LZ_BLANK_EN.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int BLANK_CYC  = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic clk,
  input  logic rst_n,
  seg7_scan_driver_if.slave bus
);

  localparam int   CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int   IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic POL_LOW = (ACTIVE_LOW != 0);
  localparam logic [6:0] SEG_IDLE = seg_polarity(SEG_OFF, POL_LOW);
  localparam logic [NUM_DIGITS-1:0] DIG_IDLE = POL_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  logic [4*NUM_DIGITS-1:0] r_value;
  logic [CNT_W-1:0]        r_cnt;
  logic [IDX_W-1:0]        r_idx;
  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_dig;
  logic                    r_frame;

  logic                    w_cnt_wrap;
  logic                    w_last_idx;
  logic                    w_blank;
  logic                    w_lz;
  logic [3:0]              w_nibble;
  logic [6:0]              w_pat_al;
  logic [NUM_DIGITS-1:0]   w_onehot;

  assign w_cnt_wrap = (r_cnt == CNT_W'(SCAN_DIV - 1));
  assign w_last_idx = (r_idx == IDX_W'(NUM_DIGITS - 1));
  assign w_blank    = (32'(r_cnt) < BLANK_CYC);
  assign w_nibble   = r_value[4*r_idx +: 4];
  assign w_onehot   = NUM_DIGITS'(1) << r_idx;

`ifdef SEG7_LZ_BLANK_EN
  // A digit is a leading zero when it and every nibble above it are zero
  assign w_lz = (r_idx != '0) && ((r_value >> (4*r_idx)) == '0);
`else
  assign w_lz = 1'b0;
`endif

  seg7_hex_lut u_lut (
    .i_nibble (w_nibble),
    .o_seg    (w_pat_al)
  );

  // Scan state plus output registers, one cycle behind cnt/idx/value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_value <= '0;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_seg   <= SEG_IDLE;
      r_dig   <= DIG_IDLE;
      r_frame <= 1'b0;
    end else begin
      if (bus.load) r_value <= bus.value_in;
      r_cnt <= w_cnt_wrap ? '0 : r_cnt + 1'b1;
      if (w_cnt_wrap) r_idx <= w_last_idx ? '0 : r_idx + 1'b1;
      r_seg   <= w_blank ? SEG_IDLE : seg_polarity(w_lz ? SEG_OFF : w_pat_al, POL_LOW);
      r_dig   <= w_blank ? DIG_IDLE : (POL_LOW ? ~w_onehot : w_onehot);
      r_frame <= w_cnt_wrap && w_last_idx;
    end
  end

  assign bus.seg_out    = r_seg;
  assign bus.dig_sel    = r_dig;
  assign bus.frame_done = r_frame;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: three configurations driven from one stimulus and
// compared every cycle against a time-based model, plus literal spot values.
module tb_seg7_scan_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        tb_load;
  logic [15:0] tb_val;
  logic        cmp_en = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  seg7_scan_driver_if #(.NUM_DIGITS(4)) bus0 ();
  seg7_scan_driver_if #(.NUM_DIGITS(4)) bus1 ();
  seg7_scan_driver_if #(.NUM_DIGITS(1)) bus2 ();

  assign bus0.load = tb_load;
  assign bus0.value_in = tb_val;
  assign bus1.load = tb_load;
  assign bus1.value_in = tb_val;
  assign bus2.load = tb_load;
  assign bus2.value_in = tb_val[3:0];

  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .ACTIVE_LOW(1))
    u0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .ACTIVE_LOW(0))
    u1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  seg7_scan_driver #(.NUM_DIGITS(1), .SCAN_DIV(3), .BLANK_CYC(0), .ACTIVE_LOW(1))
    u2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  logic [6:0] hex_al [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  // Model state: edges since reset release, register value after the latest edge
  // and after the edge before it.
  longint      m_t;
  logic [15:0] m_val;
  logic [15:0] m_val_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_t     <= 0;
      m_val   <= '0;
      m_val_d <= '0;
    end else begin
      m_t     <= m_t + 1;
      m_val_d <= m_val;
      if (tb_load) m_val <= tb_val;
    end
  end

  // Outputs after edge k reflect the scan position after edge k-1:
  // cnt = (k-1) mod sd, idx = ((k-1) div sd) mod nd.
  function automatic void expect_out(input int nd, input int sd, input int bc, input int al,
                                     input longint k, input logic [31:0] val,
                                     output logic [6:0] seg, output logic [7:0] dig,
                                     output logic fd);
    longint c;
    longint i;
    logic [6:0] pat;
    logic [7:0] mask;
    logic [7:0] onehot;
    mask = 8'((1 << nd) - 1);
    seg  = (al != 0) ? 7'h7f : 7'h00;
    dig  = (al != 0) ? mask : 8'h00;
    fd   = 1'b0;
    if (k == 0) return;
    c  = (k - 1) % sd;
    i  = ((k - 1) / sd) % nd;
    fd = ((k % (sd * nd)) == 0);
    if (c < bc) return;
    pat = hex_al[int'((val >> (4 * i)) & 32'hF)];
`ifdef SEG7_LZ_BLANK_EN
    if (i > 0 && (val >> (4 * i)) == 0) pat = 7'h7f;
`endif
    onehot = 8'(1) << i;
    seg = (al != 0) ? pat : ~pat;
    dig = (al != 0) ? (~onehot & mask) : onehot;
  endfunction

  task automatic check(input string nm, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [6:0] s;
    logic [7:0] d;
    logic f;
    expect_out(4, 8, 2, 1, m_t, {16'h0, m_val_d}, s, d, f);
    check("u0 seg", {1'b0, bus0.seg_out}, {1'b0, s});
    check("u0 dig", {4'b0, bus0.dig_sel}, d);
    check("u0 frame", {7'b0, bus0.frame_done}, {7'b0, f});
    expect_out(4, 8, 2, 0, m_t, {16'h0, m_val_d}, s, d, f);
    check("u1 seg", {1'b0, bus1.seg_out}, {1'b0, s});
    check("u1 dig", {4'b0, bus1.dig_sel}, d);
    check("u1 frame", {7'b0, bus1.frame_done}, {7'b0, f});
    expect_out(1, 3, 0, 1, m_t, {16'h0, m_val_d}, s, d, f);
    check("u2 seg", {1'b0, bus2.seg_out}, {1'b0, s});
    check("u2 dig", {7'b0, bus2.dig_sel}, d);
    check("u2 frame", {7'b0, bus2.frame_done}, {7'b0, f});
  endtask

  always @(negedge clk) begin
    if (cmp_en) check_model();
  end

  task automatic lit0(input string nm, input logic [3:0] dig, input logic [6:0] seg);
    check({nm, " u0 dig"}, {4'b0, bus0.dig_sel}, {4'b0, dig});
    check({nm, " u0 seg"}, {1'b0, bus0.seg_out}, {1'b0, seg});
  endtask

  task automatic lit1(input string nm, input logic [3:0] dig, input logic [6:0] seg);
    check({nm, " u1 dig"}, {4'b0, bus1.dig_sel}, {4'b0, dig});
    check({nm, " u1 seg"}, {1'b0, bus1.seg_out}, {1'b0, seg});
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    tb_load = 1'b0;
    tb_val  = '0;
    rst_n   = 1'b1;
    #2 rst_n = 1'b0;
    cmp_en = 1'b1;
    #1;
    lit0("reset", 4'b1111, 7'b1111111);
    lit1("reset", 4'b0000, 7'b0000000);
    check("reset u0 frame", {7'b0, bus0.frame_done}, 8'h00);

    // Release, load 12AF on edge 1, then walk the four digit slots
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tb_load = 1'b1;
    tb_val  = 16'h12AF;
    edges(1);
    tb_load = 1'b0;
    lit0("blank", 4'b1111, 7'b1111111);
    edges(2);
    lit0("digit0 F", 4'b1110, 7'b0001110);
    lit1("digit0 F", 4'b0001, 7'b1110001);
    edges(8);
    lit0("digit1 A", 4'b1101, 7'b0001000);
    edges(8);
    lit0("digit2 2", 4'b1011, 7'b0100100);
    edges(8);
    lit0("digit3 1", 4'b0111, 7'b1111001);
    edges(4);
    check("frame before end", {7'b0, bus0.frame_done}, 8'h00);
    edges(1);
    check("frame at end", {7'b0, bus0.frame_done}, 8'h01);
    edges(1);
    check("frame one wide", {7'b0, bus0.frame_done}, 8'h00);

    // Load 0000 while digit1 is at cnt=4 (sampled on edge 45)
    edges(11);
    tb_load = 1'b1;
    tb_val  = 16'h0000;
    edges(1);
    tb_load = 1'b0;
    lit0("mid-slot old", 4'b1101, 7'b0001000);
    edges(1);
`ifdef SEG7_LZ_BLANK_EN
    lit0("mid-slot new", 4'b1101, 7'b1111111);
`else
    lit0("mid-slot new", 4'b1101, 7'b1000000);
`endif
    edges(2);
    check("slot end cnt7", {4'b0, bus0.dig_sel}, 8'b0000_1101);
    edges(1);
    check("next slot blank", {4'b0, bus0.dig_sel}, 8'b0000_1111);

    // 0008 on the inverted-polarity instance
    tb_load = 1'b1;
    tb_val  = 16'h0008;
    edges(1);
    tb_load = 1'b0;
    edges(17);
    lit1("act-high 8", 4'b0001, 7'b1111111);
    lit0("act-low 8", 4'b1110, 7'b0000000);

    // 0005: leading zeros on digits 3..1
    tb_load = 1'b1;
    tb_val  = 16'h0005;
    edges(1);
    tb_load = 1'b0;
    edges(23);
`ifdef SEG7_LZ_BLANK_EN
    lit0("lz digit3", 4'b0111, 7'b1111111);
`else
    lit0("lz digit3", 4'b0111, 7'b1000000);
`endif
    edges(8);
    lit0("lz digit0", 4'b1110, 7'b0010010);

    // Asynchronous reset in the middle of digit2 (after edge 115)
    edges(16);
    #2 rst_n = 1'b0;
    #1;
    lit0("async reset", 4'b1111, 7'b1111111);
    lit1("async reset", 4'b0000, 7'b0000000);
    check("async reset frame", {7'b0, bus0.frame_done}, 8'h00);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    edges(3);
    lit0("restart digit0", 4'b1110, 7'b1000000);

    // Randomized loads with occasional asynchronous resets
    for (int n = 0; n < 2500; n++) begin
      @(posedge clk);
      #1;
      tb_load = (($urandom % 6) == 0);
      case ($urandom % 4)
        0:       tb_val = 16'h0000;
        1:       tb_val = 16'($urandom % 16);
        2:       tb_val = 16'($urandom & 32'h00FF);
        default: tb_val = 16'($urandom);
      endcase
      if (($urandom % 400) == 0) begin
        tb_load = 1'b0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
      end
    end
    tb_load = 1'b0;
    edges(2);
    cmp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
